trap_ctrl: RTL

Machine-mode trap/interrupt sequencer sitting between the commit (WB) stage and the CSR file. It arbitrates exceptions, pending interrupts and mret for the committing instruction. It drives the CSR update strobes (mepc/mcause/mtval/mstatus stack) and stalls/flushes the pipeline. It then hands a redirect PC to fetch over a valid/ready handshake.

---
 rtl/trap_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap/interrupt sequencer between the commit (WB) stage and
//   the CSR file. For the committing instruction it arbitrates pending
//   interrupts, synchronous exceptions and mret. It strobes the CSR updates
//   (mepc/mcause/mtval/mstatus.MIE stack) and stalls/flushes the pipeline. It
//   then presents the redirect PC to fetch over a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   wb_valid, wb_pc, wb_mret committing instruction
//   exc_*                    exception flags of the committing instruction
//   exc_info                 faulting address / instruction word for mtval
//   mstatus_mie, mie_*, mip_*  interrupt enable/pending state from CSR file
//   mtvec, mepc              trap vector and return address from CSR file
//   mstatus_mie_clear/set    trap-entry / mret MIE stack strobes
//   mepc_update/mepc_in      mepc write
//   mtval_update/mtval_in    mtval write
//   mcause_update/trap_type/mcause_in  mcause write (trap_type 1 = interrupt)
//   stall, flush             pipeline hold / kill IF..MEM
//   redirect_valid/pc/ready  fetch redirect handshake
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [WIDTH-1:0] wb_pc,
  input  logic             wb_mret,
  input  logic             exc_inst_misalign,
  input  logic             exc_illegal,
  input  logic             exc_ebreak,
  input  logic             exc_ecall,
  input  logic             exc_load_misalign,
  input  logic             exc_store_misalign,
  input  logic [WIDTH-1:0] exc_info,
  input  logic             mstatus_mie,
  input  logic             mie_sw,
  input  logic             mie_timer,
  input  logic             mie_external,
  input  logic             mip_sw,
  input  logic             mip_timer,
  input  logic             mip_external,
  input  logic [WIDTH-1:0] mtvec,
  input  logic [WIDTH-1:0] mepc,
  output logic             mstatus_mie_clear,
  output logic             mstatus_mie_set,
  output logic             mepc_update,
  output logic [WIDTH-1:0] mepc_in,
  output logic             mtval_update,
  output logic [WIDTH-1:0] mtval_in,
  output logic             mcause_update,
  output logic             trap_type,
  output logic [3:0]       mcause_in,
  output logic             stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ready
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRAP_REDIR = 2'd1,
    MRET_REDIR = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cause;
  logic             r_irq;

  logic             w_int_ext;
  logic             w_int_sw;
  logic             w_int_tmr;
  logic             w_irq;
  logic [3:0]       w_irq_cause;
  logic             w_exc;
  logic [3:0]       w_exc_cause;
  logic [WIDTH-1:0] w_exc_mtval;
  logic [3:0]       w_cause;
  logic             w_accept;
  logic             w_trap;
  logic             w_mret;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_vec_pc;

  // Interrupt arbitration: external > software > timer.
  assign w_int_ext = mie_external & mip_external;
  assign w_int_sw  = mie_sw & mip_sw;
  assign w_int_tmr = mie_timer & mip_timer;
  assign w_irq     = mstatus_mie & (w_int_ext | w_int_sw | w_int_tmr);

  always_comb begin
    w_irq_cause = 4'd7;
    if (w_int_ext) begin
      w_irq_cause = 4'd11;
    end else if (w_int_sw) begin
      w_irq_cause = 4'd3;
    end
  end

  // Exception arbitration in fixed priority order, with the matching mtval.
  assign w_exc = exc_inst_misalign | exc_illegal | exc_ebreak | exc_ecall |
                 exc_load_misalign | exc_store_misalign;

  always_comb begin
    w_exc_cause = 4'd0;
    w_exc_mtval = '0;
    if (exc_inst_misalign) begin
      w_exc_cause = 4'd0;
      w_exc_mtval = exc_info;
    end else if (exc_illegal) begin
      w_exc_cause = 4'd2;
      w_exc_mtval = exc_info;
    end else if (exc_ebreak) begin
      w_exc_cause = 4'd3;
      w_exc_mtval = wb_pc;
    end else if (exc_ecall) begin
      w_exc_cause = 4'd11;
      w_exc_mtval = '0;
    end else if (exc_load_misalign) begin
      w_exc_cause = 4'd4;
      w_exc_mtval = exc_info;
    end else if (exc_store_misalign) begin
      w_exc_cause = 4'd6;
      w_exc_mtval = exc_info;
    end
  end

  // rst is folded into accept so no strobe can leak out while reset is held.
  assign w_accept = (r_state == IDLE) & wb_valid & ~rst;
  assign w_trap   = w_accept & (w_irq | w_exc);
  assign w_mret   = w_accept & wb_mret & ~w_irq & ~w_exc;
  assign w_cause  = w_irq ? w_irq_cause : w_exc_cause;

  // Only interrupts in vectored mode (mtvec[1:0]==01) get an offset; mode 3
  // and all exceptions go to the base address.
  assign w_base   = {mtvec[WIDTH-1:2], 2'b00};
  assign w_vec_pc = ((mtvec[1:0] == 2'b01) && r_irq) ?
                    (w_base + (WIDTH'(r_cause) << 2)) : w_base;

  always_comb begin
    w_next            = r_state;
    mstatus_mie_clear = 1'b0;
    mstatus_mie_set   = 1'b0;
    mepc_update       = 1'b0;
    mepc_in           = '0;
    mtval_update      = 1'b0;
    mtval_in          = '0;
    mcause_update     = 1'b0;
    trap_type         = 1'b0;
    mcause_in         = 4'd0;
    stall             = 1'b0;
    flush             = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    case (r_state)
      IDLE: begin
        if (w_trap) begin
          stall             = 1'b1;
          flush             = 1'b1;
          mepc_update       = 1'b1;
          mepc_in           = wb_pc;
          mcause_update     = 1'b1;
          trap_type         = w_irq;
          mcause_in         = w_cause;
          mstatus_mie_clear = 1'b1;
          mtval_update      = 1'b1;
          mtval_in          = w_irq ? '0 : w_exc_mtval;
          w_next            = TRAP_REDIR;
        end else if (w_mret) begin
          stall           = 1'b1;
          flush           = 1'b1;
          mstatus_mie_set = 1'b1;
          w_next          = MRET_REDIR;
        end
      end
      TRAP_REDIR: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = w_vec_pc;
        if (redirect_ready) begin
          w_next = IDLE;
        end
      end
      MRET_REDIR: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
        if (redirect_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cause <= 4'd0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_trap) begin
        r_cause <= w_cause;
        r_irq   <= w_irq;
      end
    end
  end

endmodule
